sprite_draw_sched: RTL and testbench
====================================

Name: sprite_draw_sched

Overview:
- Schedules the single VGA adapter write port (x, y, colour, plot) among several 8x8 sprite owners, e.g. the player car and obstacles.
- For each accepted move request it first erases the sprite at the owner's previous position, then redraws it from the sprite ROM at the new position.
- Sits between the game-logic position registers and the vga_adapter at 160x120 resolution, 3-bit colour.
- Replaces free-running pixel counters with a request/grant sequenced draw.

Parameters:
- N_REQ, 2: number of requesters (1..4).
- ERASE_COLOUR, 3'b000: colour written during the erase pass.
- SPR_LOG2, 3: sprite edge log2; sprite is 8x8 and the ROM address is 6 bits.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  synchronous active-low reset.
- req  in  N_REQ  level request per owner; held until gnt.
- req_x  in  8*N_REQ  new top-left x per owner; slice i = bits [8i+7:8i].
- req_y  in  7*N_REQ  new top-left y per owner; slice i = bits [7i+6:7i].
- gnt  out  N_REQ  one-cycle one-hot pulse when the request is accepted.
- rom_sel  out  2  index of the owner currently drawing; selects the sprite ROM.
- rom_addr  out  6  {row, col} address into the sprite ROM.
- rom_data  in  3  pixel colour, valid one cycle after rom_addr.
- oX  out  8  pixel x to vga_adapter.
- oY  out  7  pixel y to vga_adapter.
- oColour  out  3  pixel colour to vga_adapter.
- plot  out  1  write strobe to vga_adapter.
- busy  out  1  high from the gnt cycle until done, inclusive.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0; per-owner old_valid = 0.
- Reset asserted mid-sequence: the same reset applies on the next edge, the sequence is abandoned with no done pulse, and plot drops to 0 in that cycle.
- State IDLE:
  - If any req bit is high, the round-robin arbiter picks the lowest index at or after the pointer (wrapping).
  - In the same cycle it pulses gnt[i] and latches cur = i, new_x = req_x[i], new_y = req_y[i].
  - The pointer moves to i+1 mod N_REQ.
  - Next state is ERASE if old_valid[i], else DRAW.
- State ERASE:
  - A 6-bit counter {row, col} runs 0..63; col increments first.
  - Each cycle: oX = old_x[cur] + col, oY = old_y[cur] + row, oColour = ERASE_COLOUR, plot = 1 subject to clipping.
  - At count 63 the state moves to DRAW and the counter resets to 0.
- State DRAW:
  - rom_addr = counter for counts 0..63; rom_sel = cur throughout.
  - One-stage pipeline: the pixel for address k is output in the next cycle, with oX = new_x + col_k, oY = new_y + row_k, oColour = rom_data, plot = 1 subject to clipping.
  - After address 63 the state moves to FLUSH for one cycle, which outputs pixel 63.
- State DONE (one cycle):
  - done = 1; old_x/old_y[cur] <= new_x/new_y; old_valid[cur] <= 1.
  - Next state is IDLE; no grant is issued in the DONE cycle.
- Timing with gnt in cycle 0:
  - With erase: erase pixels in cycles 1..64, draw pixels in cycles 66..129, done in cycle 130.
  - Without erase: draw pixels in cycles 2..65, done in cycle 66.
- Arithmetic: coordinate sums are carried in 9/8 bits.
  - plot is forced to 0 when the sum x >= 160 or y >= 120 (clipping); the cycle is still consumed.
  - oX/oY carry the truncated sums.
- Requests arriving while busy stay pending because req is a level signal. req_x/req_y are sampled only in the gnt cycle.
- Identical old and new position: the full erase+draw is still performed.
- Only one owner draws at a time; there are no interleaved pixels.

Optional Feature:
- Macro SPRITE_TRANSPARENCY_EN, with package constant TRANSPARENT_COLOUR = 3'b101.
- When defined: during DRAW, a pixel with rom_data == TRANSPARENT_COLOUR forces plot = 0, so the background remains. Timing is unchanged.
- When undefined: every in-bounds pixel is plotted.

Decomposition:
- Package car_game_pkg:
  - SCREEN_W = 160, SCREEN_H = 120, COLOUR_W = 3, X_W = 8, Y_W = 7, SPR_PIX = 64, TRANSPARENT_COLOUR.
  - State enum {IDLE, ERASE, DRAW, FLUSH, DONE}.
- Sub-module rr_arbiter: inputs req and pointer; outputs one-hot gnt and the encoded index. It is purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset, then req[0] with x=75, y=70, no prior draw:
  - gnt[0] in cycle 0.
  - 64 plots covering x 75..82, y 70..77, with colour equal to ROM data delayed one cycle.
  - done in cycle 66.
- After the above, req[0] with x=40:
  - 64 plots at x 75..82 with colour 000, then 64 plots at x 40..47.
  - done in cycle 130; old position updated to (40,70).
- req=2'b11 in the same cycle from reset:
  - Owner 0 is granted first; owner 1 is granted in the first IDLE after done.
  - A later simultaneous request grants owner 0 (pointer wrapped).
- req[1] with x=156, y=116:
  - Only 16 plot pulses (cols 156..159 × rows 116..119).
  - done still arrives at cycle 66.
- Resetn low at cycle 30 of ERASE:
  - Next cycle: plot=0, busy=0, no done.
  - A following req[0] takes the no-erase path (old_valid cleared).
- With SPRITE_TRANSPARENCY_EN and a ROM holding 3'b101 at addresses 0..31:
  - Exactly 32 draw plots (rows 4..7).
  - done timing is unchanged.

Source files
------------

// File: rtl/car_game_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// car_game_pkg : screen geometry, colour constants and draw-scheduler states
// rev 1.0
// ----------------------------------------------------------------------------
package car_game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int SPR_PIX  = 64;

    localparam logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 3'b101;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ERASE = 3'd1;
    localparam logic [2:0] ST_DRAW  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ERASE = ST_ERASE,
        DRAW  = ST_DRAW,
        FLUSH = ST_FLUSH,
        DONE  = ST_DONE
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, lowest index at/after pointer
// rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       pointer,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       idx
);

    logic found;

    // First pass covers indices at/after the pointer; the second pass is the
    // wrap-around, where the lowest requesting index wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (2'(j) >= pointer)) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = 2'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = 2'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_draw_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sprite_draw_sched : erase/redraw sequencer for 8x8 sprites on a 160x120 VGA
// write port. Optional macro SPRITE_TRANSPARENCY_EN skips transparent pixels.
// rev 1.0
// ----------------------------------------------------------------------------
module sprite_draw_sched
    import car_game_pkg::*;
#(
    parameter int                  N_REQ        = 2,
    parameter logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000,
    parameter int                  SPR_LOG2     = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [N_REQ-1:0]      req,
    input  logic [X_W*N_REQ-1:0]  req_x,
    input  logic [Y_W*N_REQ-1:0]  req_y,
    output logic [N_REQ-1:0]      gnt,
    output logic [1:0]            rom_sel,
    output logic [5:0]            rom_addr,
    input  logic [COLOUR_W-1:0]   rom_data,
    output logic [X_W-1:0]        oX,
    output logic [Y_W-1:0]        oY,
    output logic [COLOUR_W-1:0]   oColour,
    output logic                  plot,
    output logic                  busy,
    output logic                  done
);

    localparam int MAX_REQ = 4;
    localparam int CNT_W   = 2 * SPR_LOG2;
    localparam int SX_W    = X_W + 1;
    localparam int SY_W    = Y_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPR_PIX - 1);

    state_e               state;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           cur;
    logic [1:0]           ptr;
    logic [X_W-1:0]       new_x;
    logic [Y_W-1:0]       new_y;
    logic [X_W-1:0]       old_x [MAX_REQ];
    logic [Y_W-1:0]       old_y [MAX_REQ];
    logic [MAX_REQ-1:0]   old_valid;

    // Draw pipeline stage: coordinates of the address issued last cycle.
    logic                 d_valid;
    logic [X_W-1:0]       d_x;
    logic [Y_W-1:0]       d_y;
    logic                 d_inb;

    logic [X_W-1:0]       in_x [MAX_REQ];
    logic [Y_W-1:0]       in_y [MAX_REQ];
    logic [N_REQ-1:0]     arb_gnt;
    logic [1:0]           arb_idx;
    logic                 any_req;

    logic [SPR_LOG2-1:0]  col;
    logic [SPR_LOG2-1:0]  row;
    logic [SX_W-1:0]      sx_old;
    logic [SX_W-1:0]      sx_new;
    logic [SY_W-1:0]      sy_old;
    logic [SY_W-1:0]      sy_new;
    logic                 inb_old;
    logic                 inb_new;
    logic                 px_visible;

    generate
        for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
            if (i < N_REQ) begin : g_used
                assign in_x[i] = req_x[X_W*i +: X_W];
                assign in_y[i] = req_y[Y_W*i +: Y_W];
            end else begin : g_pad
                assign in_x[i] = '0;
                assign in_y[i] = '0;
            end
        end
    endgenerate

    rr_arbiter #(
        .N_REQ   (N_REQ)
    ) u_arb (
        .req     (req),
        .pointer (ptr),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    assign any_req = |req;
    assign gnt     = (Resetn && state == IDLE) ? arb_gnt : '0;
    assign busy    = Resetn && ((state != IDLE) || any_req);
    assign done    = (state == DONE);
    assign rom_sel = cur;

    assign col     = cnt[SPR_LOG2-1:0];
    assign row     = cnt[CNT_W-1:SPR_LOG2];
    assign sx_old  = {1'b0, old_x[cur]} + SX_W'(col);
    assign sy_old  = {1'b0, old_y[cur]} + SY_W'(row);
    assign sx_new  = {1'b0, new_x} + SX_W'(col);
    assign sy_new  = {1'b0, new_y} + SY_W'(row);
    assign inb_old = (sx_old < SX_W'(SCREEN_W)) && (sy_old < SY_W'(SCREEN_H));
    assign inb_new = (sx_new < SX_W'(SCREEN_W)) && (sy_new < SY_W'(SCREEN_H));

`ifdef SPRITE_TRANSPARENCY_EN
    assign px_visible = (rom_data != TRANSPARENT_COLOUR);
`else
    assign px_visible = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            cur       <= '0;
            ptr       <= '0;
            new_x     <= '0;
            new_y     <= '0;
            old_valid <= '0;
            d_valid   <= 1'b0;
            d_x       <= '0;
            d_y       <= '0;
            d_inb     <= 1'b0;
            for (int i = 0; i < MAX_REQ; i++) begin
                old_x[i] <= '0;
                old_y[i] <= '0;
            end
        end else begin
            d_valid <= (state == DRAW);
            d_x     <= sx_new[X_W-1:0];
            d_y     <= sy_new[Y_W-1:0];
            d_inb   <= inb_new;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        cur   <= arb_idx;
                        new_x <= in_x[arb_idx];
                        new_y <= in_y[arb_idx];
                        ptr   <= (arb_idx == 2'(N_REQ - 1)) ? 2'd0 : arb_idx + 2'd1;
                        state <= old_valid[arb_idx] ? ERASE : DRAW;
                    end
                end
                ERASE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= DONE;
                end
                DONE: begin
                    old_x[cur]     <= new_x;
                    old_y[cur]     <= new_y;
                    old_valid[cur] <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Erase pixels leave in the counter cycle; draw pixels wait one cycle
    // for the ROM so colour and coordinates line up.
    always_comb begin
        oX       = '0;
        oY       = '0;
        oColour  = '0;
        plot     = 1'b0;
        rom_addr = '0;
        if (state == DRAW) begin
            rom_addr = cnt;
        end
        if (state == ERASE) begin
            oX      = sx_old[X_W-1:0];
            oY      = sy_old[Y_W-1:0];
            oColour = ERASE_COLOUR;
            plot    = inb_old;
        end else if (d_valid) begin
            oX      = d_x;
            oY      = d_y;
            oColour = rom_data;
            plot    = d_inb && px_visible;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_draw_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_sprite_draw_sched : timeline reference model, directed + random requests
// rev 1.0
// ----------------------------------------------------------------------------
module tb_sprite_draw_sched;

    localparam int N = 2;
`ifdef SPRITE_TRANSPARENCY_EN
    localparam int EXP_FULL = 32;
    localparam int EXP_MINY = 74;
`else
    localparam int EXP_FULL = 64;
    localparam int EXP_MINY = 70;
`endif

    logic          Clock = 1'b0;
    logic          Resetn;
    logic [N-1:0]  req;
    logic [8*N-1:0] req_x;
    logic [7*N-1:0] req_y;
    logic [N-1:0]  gnt;
    logic [1:0]    rom_sel;
    logic [5:0]    rom_addr;
    logic [2:0]    rom_data = 3'd0;
    logic [7:0]    oX;
    logic [6:0]    oY;
    logic [2:0]    oColour;
    logic          plot;
    logic          busy;
    logic          done;

    always #5 Clock = ~Clock;

    sprite_draw_sched #(
        .N_REQ        (N),
        .ERASE_COLOUR (3'b000),
        .SPR_LOG2     (3)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .req      (req),
        .req_x    (req_x),
        .req_y    (req_y),
        .gnt      (gnt),
        .rom_sel  (rom_sel),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .oX       (oX),
        .oY       (oY),
        .oColour  (oColour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [2:0] rom_fn(input int sel, input int addr);
        int v;
        v = (addr * 3 + sel * 5 + addr / 8) % 8;
`ifdef SPRITE_TRANSPARENCY_EN
        if (sel == 0 && addr < 32) return 3'd5;
        if (v == 5) v = 6;
`endif
        return 3'(v);
    endfunction

    // Sprite ROM with one cycle of read latency.
    always @(posedge Clock) rom_data <= rom_fn(int'(rom_sel), int'(rom_addr));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Pinned literal expectations, written by the stimulus, checked at done #pin_at.
    int pin_at = -1;
    int pin_off, pin_plots, pin_minx, pin_maxx, pin_miny, pin_maxy, pin_firstx, pin_gnt, pin_gap;
    logic tmo = 1'b0;

    // Reference model state: one sequence at a time, described by its timeline.
    int m_busy = 0, m_t = 0, m_cur = 0, m_er = 0, m_nx = 0, m_ny = 0, m_ptr = 0;
    int m_ox [N];
    int m_oy [N];
    int m_ov [N];
    int m_gnt_last = 0;
    int rst_known = 0;

    int done_count = 0, last_done_cyc = 0;
    int s_start = 0, s_plots = 0, s_minx = 0, s_maxx = 0, s_miny = 0, s_maxy = 0;
    int s_firstx = -1, s_firstc = 0, s_gnt = 0, s_gap = 0;
    int tmo_rep = 0;

    always @(negedge Clock) begin
        int e_gnt, e_busy, e_done, e_plot, e_x, e_y, e_c, pix, off, k, bx, by, sx, sy, found, j;
        cyc++;
        m_gnt_last = 0;
        if (!Resetn) begin
            if (rst_known != 0) begin
                chk("rst_gnt", 32'(gnt), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_plot", 32'(plot), 0);
                chk("rst_done", 32'(done), 0);
            end
            m_busy = 0;
            m_ptr = 0;
            for (int i = 0; i < N; i++) m_ov[i] = 0;
            rst_known = 1;
        end else begin
            rst_known = 0;
            e_gnt = 0; e_busy = 0; e_done = 0; e_plot = 0; pix = 0;
            e_x = 0; e_y = 0; e_c = 0;
            if (m_busy == 0) begin
                found = 0; j = 0;
                for (int q = 0; q < N; q++) begin
                    if (found == 0 && req[(m_ptr + q) % N]) begin
                        found = 1;
                        j = (m_ptr + q) % N;
                    end
                end
                if (found != 0) begin
                    e_gnt = 1 << j; e_busy = 1;
                    m_busy = 1; m_t = 0; m_cur = j; m_er = m_ov[j];
                    m_nx = int'(req_x[8*j +: 8]); m_ny = int'(req_y[7*j +: 7]);
                    m_ptr = (j + 1) % N;
                    m_gnt_last = e_gnt;
                end
            end else begin
                m_t++;
                e_busy = 1;
                off = (m_er != 0) ? 64 : 0;
                if (m_er != 0 && m_t <= 64) begin
                    pix = 1; k = m_t - 1; bx = m_ox[m_cur]; by = m_oy[m_cur]; e_c = 0;
                end else if (m_t >= 2 + off && m_t <= 65 + off) begin
                    pix = 2; k = m_t - 2 - off; bx = m_nx; by = m_ny; e_c = int'(rom_fn(m_cur, k));
                end
                if (pix != 0) begin
                    sx = bx + k % 8;
                    sy = by + k / 8;
                    e_plot = (sx < 160 && sy < 120) ? 1 : 0;
`ifdef SPRITE_TRANSPARENCY_EN
                    if (pix == 2 && e_c == 5) e_plot = 0;
`endif
                    e_x = sx % 256;
                    e_y = sy % 128;
                end
                if (m_t >= 1 + off && m_t <= 64 + off) begin
                    chk("rom_addr", 32'(rom_addr), 32'(m_t - 1 - off));
                    chk("rom_sel", 32'(rom_sel), 32'(m_cur));
                end
                if (m_t == 66 + off) begin
                    e_done = 1;
                    m_ox[m_cur] = m_nx; m_oy[m_cur] = m_ny; m_ov[m_cur] = 1;
                    m_busy = 0;
                end
            end
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("plot", 32'(plot), 32'(e_plot));
            if (pix != 0) begin
                chk("oX", 32'(oX), 32'(e_x));
                chk("oY", 32'(oY), 32'(e_y));
                chk("oColour", 32'(oColour), 32'(e_c));
            end

            // Observed per-sequence statistics for the pinned literal checks.
            if (gnt != '0) begin
                s_start = cyc; s_plots = 0; s_gnt = int'(gnt); s_gap = cyc - last_done_cyc;
                s_minx = 999; s_maxx = -1; s_miny = 999; s_maxy = -1; s_firstx = -1;
            end
            if (plot) begin
                s_plots++;
                if (int'(oX) < s_minx) s_minx = int'(oX);
                if (int'(oX) > s_maxx) s_maxx = int'(oX);
                if (int'(oY) < s_miny) s_miny = int'(oY);
                if (int'(oY) > s_maxy) s_maxy = int'(oY);
                if (s_firstx < 0) begin s_firstx = int'(oX); s_firstc = int'(oColour); end
            end
            if (done) begin
                done_count++;
                last_done_cyc = cyc;
                if (done_count == pin_at) begin
                    chk("done_latency", 32'(cyc - s_start), 32'(pin_off));
                    chk("grant_vec", 32'(s_gnt), 32'(pin_gnt));
                    if (pin_plots >= 0) chk("plot_count", 32'(s_plots), 32'(pin_plots));
                    if (pin_minx >= 0) begin
                        chk("min_x", 32'(s_minx), 32'(pin_minx));
                        chk("max_x", 32'(s_maxx), 32'(pin_maxx));
                        chk("min_y", 32'(s_miny), 32'(pin_miny));
                        chk("max_y", 32'(s_maxy), 32'(pin_maxy));
                    end
                    if (pin_firstx >= 0) begin
                        chk("first_x", 32'(s_firstx), 32'(pin_firstx));
                        chk("first_colour", 32'(s_firstc), 0);
                    end
                    if (pin_gap >= 0) chk("grant_gap", 32'(s_gap), 32'(pin_gap));
                end
            end
        end
        if (tmo && tmo_rep == 0) begin
            chk("wait_timeout", 32'(tmo), 0);
            tmo_rep = 1;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        req = req & ~N'(m_gnt_last);
    endtask

    task automatic set_req(input int i, input int x, input int y);
        req_x[8*i +: 8] = 8'(x);
        req_y[7*i +: 7] = 7'(y);
        req[i] = 1'b1;
    endtask

    task automatic pin(input int off, input int plots, input int minx, input int maxx,
                       input int miny, input int maxy, input int firstx, input int g, input int gap);
        pin_at = done_count + 1;
        pin_off = off; pin_plots = plots; pin_minx = minx; pin_maxx = maxx;
        pin_miny = miny; pin_maxy = maxy; pin_firstx = firstx; pin_gnt = g; pin_gap = gap;
    endtask

    task automatic wait_done(input int budget);
        int target;
        target = done_count + 1;
        for (int n = 0; n < budget && done_count < target; n++) tick();
        if (done_count < target) tmo = 1'b1;
    endtask

    task automatic do_reset(input int n);
        Resetn = 1'b0;
        req = '0;
        repeat (n) tick();
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b0;
        req = '0;
        req_x = '0;
        req_y = '0;
        repeat (3) tick();
        Resetn = 1'b1;

        // First draw of owner 0, no erase.
        pin(66, EXP_FULL, 75, 82, EXP_MINY, 77, -1, 1, -1);
        set_req(0, 75, 70);
        wait_done(300);
        tick();

        // Move owner 0: erase at old spot then draw at x=40.
        pin(130, 64 + EXP_FULL, 40, 82, 70, 77, 75, 1, -1);
        set_req(0, 40, 70);
        wait_done(300);
        tick();

        // Same position again: erase must start at the updated (40,70).
        pin(130, -1, -1, -1, -1, -1, 40, 1, -1);
        set_req(0, 40, 70);
        wait_done(300);

        // Simultaneous requests from reset, then again after pointer wraps.
        do_reset(2);
        pin(66, -1, -1, -1, -1, -1, -1, 1, -1);
        set_req(0, 10, 5);
        set_req(1, 100, 30);
        wait_done(300);
        pin(66, -1, -1, -1, -1, -1, -1, 2, 1);
        wait_done(300);
        tick();
        pin(130, -1, -1, -1, -1, -1, -1, 1, -1);
        set_req(0, 20, 40);
        set_req(1, 120, 90);
        wait_done(300);
        pin(130, -1, -1, -1, -1, -1, -1, 2, 1);
        wait_done(300);

        // Bottom-right corner: only a 4x4 corner is on screen.
        do_reset(2);
        pin(66, 16, 156, 159, 116, 119, -1, 2, -1);
        set_req(1, 156, 116);
        wait_done(300);
        tick();

        // Reset in the middle of an erase, then a fresh no-erase draw.
        pin(66, EXP_FULL, -1, -1, -1, -1, -1, 1, -1);
        set_req(0, 10, 10);
        wait_done(300);
        tick();
        set_req(0, 20, 20);
        repeat (31) tick();
        do_reset(2);
        pin(66, EXP_FULL, 30, 37, EXP_MINY - 40, 37, -1, 1, -1);
        set_req(0, 30, 30);
        wait_done(300);

        // Randomized traffic in segments separated by resets.
        for (int seg = 0; seg < 3; seg++) begin
            do_reset(1 + seg);
            repeat (1500) begin
                tick();
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && $urandom_range(0, 15) == 0) begin
                        set_req(i,
                                ($urandom_range(0, 3) == 0) ? int'($urandom_range(148, 255)) : int'($urandom_range(0, 159)),
                                ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119)));
                    end
                end
            end
        end
        req = '0;
        repeat (140) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
